instr_decode_frontend: RTL and testbench

//  Consumer end of the fetch stream. Takes the 16-bit word stream from the fetch stage,

---
 rtl/instr_decode_frontend.sv | 158 +++++++++++++++
 tb/tb_instr_decode_frontend.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/instr_decode_frontend.sv
// Decode front end: drops bubble words, pairs opcode words with their immediate,
// splits the instruction into fields and queues it in a small FIFO for the issue stage.
//
//   state | meaning
//   S_OP  | waiting for an opcode word (bubbles dropped here)
//   S_IMM | opcode held, next accepted word is its immediate
module instr_decode_frontend #(
  parameter logic [15:0] NOP_WORD = 16'hA000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic        in_valid,
  input  logic [15:0] in_instr,
  output logic        in_ready,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [4:0]  out_opcode,
  output logic [2:0]  out_rdst,
  output logic [2:0]  out_rsrc1,
  output logic [2:0]  out_rsrc2,
  output logic        out_has_imm,
  output logic [15:0] out_imm,
  output logic [15:0] nop_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic {S_OP, S_IMM} state_t;

  state_t        state, state_nxt;

  // Opcode word minus bit 1, which carries no field: {word[15:2], word[0]}
  logic [14:0]   hold_fields;
  logic [14:0]   mem_fields [DEPTH];
  logic [15:0]   mem_imm    [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;

  logic          accept, pop;
  logic          push, hold_load, nop_inc;
  logic [14:0]   push_fields;
  logic [15:0]   push_imm;
  logic [14:0]   head_fields;

  assign in_ready  = !flush && (count < DEPTH_C);
  assign out_valid = (count != '0);
  assign accept    = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // Next-state and datapath control for word acceptance
  always_comb begin
    state_nxt   = state;
    push        = 1'b0;
    push_fields = {in_instr[15:2], in_instr[0]};
    push_imm    = 16'h0000;
    hold_load   = 1'b0;
    nop_inc     = 1'b0;
    case (state)
      S_OP: begin
        if (accept) begin
          if (in_instr == NOP_WORD) begin
            nop_inc = 1'b1;
          end else if (!in_instr[0]) begin
            push = 1'b1;
          end else begin
            hold_load = 1'b1;
            state_nxt = S_IMM;
          end
        end
      end
      S_IMM: begin
        if (accept) begin
          push        = 1'b1;
          push_fields = hold_fields;
          push_imm    = in_instr;
          state_nxt   = S_OP;
        end
      end
      default: state_nxt = S_OP;
    endcase
  end

  // State register; flush abandons any half-assembled instruction
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_OP;
    end else if (flush) begin
      state <= S_OP;
    end else begin
      state <= state_nxt;
    end
  end

  // Hold register for an opcode word awaiting its immediate
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold_fields <= '0;
    end else if (flush) begin
      hold_fields <= '0;
    end else if (hold_load) begin
      hold_fields <= {in_instr[15:2], in_instr[0]};
    end
  end

  // FIFO storage; contents are don't-care while not counted, outputs are gated below
  always_ff @(posedge clk) begin
    if (push) begin
      mem_fields[wr_ptr] <= push_fields;
      mem_imm[wr_ptr]    <= push_imm;
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Saturating count of dropped bubbles; survives flush
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      nop_count <= 16'h0000;
    end else if (nop_inc && (nop_count != 16'hFFFF)) begin
      nop_count <= nop_count + 16'h0001;
    end
  end

  // Head fields forced to zero whenever the FIFO is empty
  always_comb begin
    head_fields = out_valid ? mem_fields[rd_ptr] : 15'h0000;
    out_opcode  = head_fields[14:10];
    out_rdst    = head_fields[9:7];
    out_rsrc1   = head_fields[6:4];
    out_rsrc2   = head_fields[3:1];
    out_has_imm = head_fields[0];
    out_imm     = (out_valid && head_fields[0]) ? mem_imm[rd_ptr] : 16'h0000;
  end

endmodule

// File: tb/tb_instr_decode_frontend.sv
// Directed bench for instr_decode_frontend: a per-cycle vector table plus a
// hand-written asynchronous-reset sequence.
module tb_instr_decode_frontend;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic [15:0] in_instr;
  logic        in_ready;
  logic        out_valid;
  logic        out_ready;
  logic [4:0]  out_opcode;
  logic [2:0]  out_rdst;
  logic [2:0]  out_rsrc1;
  logic [2:0]  out_rsrc2;
  logic        out_has_imm;
  logic [15:0] out_imm;
  logic [15:0] nop_count;

  int passed = 0;
  int total  = 0;

  instr_decode_frontend dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_instr(in_instr), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_opcode(out_opcode), .out_rdst(out_rdst), .out_rsrc1(out_rsrc1),
    .out_rsrc2(out_rsrc2), .out_has_imm(out_has_imm), .out_imm(out_imm),
    .nop_count(nop_count)
  );

  always #5 clk = ~clk;

  // Inputs applied for one cycle, and the outputs expected before that cycle's edge
  typedef struct {
    logic        v;
    logic [15:0] w;
    logic        rdy;
    logic        fl;
    logic        e_valid;
    logic [4:0]  e_op;
    logic [2:0]  e_rd;
    logic [2:0]  e_s1;
    logic [2:0]  e_s2;
    logic        e_hi;
    logic [15:0] e_imm;
    logic        e_ir;
    logic [15:0] e_nop;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input int step, input logic [15:0] act,
                     input logic [15:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s step %0d: got %h expected %h", name, step, act, exp);
  endtask

  task automatic add(input logic v, input logic [15:0] w, input logic rdy, input logic fl,
                     input logic ev, input logic [4:0] op, input logic [2:0] rd,
                     input logic [2:0] s1, input logic [2:0] s2, input logic hi,
                     input logic [15:0] imm, input logic ir, input logic [15:0] nop);
    vec_t t;
    t.v = v; t.w = w; t.rdy = rdy; t.fl = fl;
    t.e_valid = ev; t.e_op = op; t.e_rd = rd; t.e_s1 = s1; t.e_s2 = s2;
    t.e_hi = hi; t.e_imm = imm; t.e_ir = ir; t.e_nop = nop;
    vecs.push_back(t);
  endtask

  task automatic chk_all(input int step, input vec_t t);
    chk("out_valid",   step, {15'h0, out_valid},   {15'h0, t.e_valid});
    chk("out_opcode",  step, {11'h0, out_opcode},  {11'h0, t.e_op});
    chk("out_rdst",    step, {13'h0, out_rdst},    {13'h0, t.e_rd});
    chk("out_rsrc1",   step, {13'h0, out_rsrc1},   {13'h0, t.e_s1});
    chk("out_rsrc2",   step, {13'h0, out_rsrc2},   {13'h0, t.e_s2});
    chk("out_has_imm", step, {15'h0, out_has_imm}, {15'h0, t.e_hi});
    chk("out_imm",     step, out_imm,              t.e_imm);
    chk("in_ready",    step, {15'h0, in_ready},    {15'h0, t.e_ir});
    chk("nop_count",   step, nop_count,            t.e_nop);
  endtask

  initial begin
    vec_t t;
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_instr = 16'h0; out_ready = 1'b0;

    //   v  word     rdy fl  valid op   rd    s1    s2    hi  imm       ir  nop
    // basic non-imm then opcode+immediate
    add(1, 16'h1234, 1, 0,  0, 5'd0, 3'd0, 3'd0, 3'd0, 0, 16'h0000, 1, 16'd0);
    add(1, 16'h0A21, 1, 0,  1, 5'd2, 3'd2, 3'd1, 3'd5, 0, 16'h0000, 1, 16'd0);
    add(1, 16'h00FF, 1, 0,  0, 5'd0, 3'd0, 3'd0, 3'd0, 0, 16'h0000, 1, 16'd0);
    add(0, 16'h0000, 1, 0,  1, 5'd1, 3'd2, 3'd1, 3'd0, 1, 16'h00FF, 1, 16'd0);
    // bubbles dropped and counted
    add(1, 16'hA000, 1, 0,  0, 5'd0, 3'd0, 3'd0, 3'd0, 0, 16'h0000, 1, 16'd0);
    add(1, 16'hA000, 1, 0,  0, 5'd0, 3'd0, 3'd0, 3'd0, 0, 16'h0000, 1, 16'd1);
    add(1, 16'hA000, 1, 0,  0, 5'd0, 3'd0, 3'd0, 3'd0, 0, 16'h0000, 1, 16'd2);
    add(1, 16'h1234, 1, 0,  0, 5'd0, 3'd0, 3'd0, 3'd0, 0, 16'h0000, 1, 16'd3);
    add(0, 16'h0000, 1, 0,  1, 5'd2, 3'd2, 3'd1, 3'd5, 0, 16'h0000, 1, 16'd3);
    add(0, 16'h0000, 1, 0,  0, 5'd0, 3'd0, 3'd0, 3'd0, 0, 16'h0000, 1, 16'd3);
    // NOP encoding taken as an immediate, not counted
    add(1, 16'h0A21, 1, 0,  0, 5'd0, 3'd0, 3'd0, 3'd0, 0, 16'h0000, 1, 16'd3);
    add(1, 16'hA000, 1, 0,  0, 5'd0, 3'd0, 3'd0, 3'd0, 0, 16'h0000, 1, 16'd3);
    add(0, 16'h0000, 1, 0,  1, 5'd1, 3'd2, 3'd1, 3'd0, 1, 16'hA000, 1, 16'd3);
    add(0, 16'h0000, 1, 0,  0, 5'd0, 3'd0, 3'd0, 3'd0, 0, 16'h0000, 1, 16'd3);
    // backpressure: FIFO fills, head stable, refill one cycle after the pop
    add(1, 16'h1234, 0, 0,  0, 5'd0, 3'd0, 3'd0, 3'd0, 0, 16'h0000, 1, 16'd3);
    add(1, 16'h0800, 0, 0,  1, 5'd2, 3'd2, 3'd1, 3'd5, 0, 16'h0000, 1, 16'd3);
    add(1, 16'h2004, 0, 0,  1, 5'd2, 3'd2, 3'd1, 3'd5, 0, 16'h0000, 0, 16'd3);
    add(1, 16'h2004, 0, 0,  1, 5'd2, 3'd2, 3'd1, 3'd5, 0, 16'h0000, 0, 16'd3);
    add(1, 16'h2004, 1, 0,  1, 5'd2, 3'd2, 3'd1, 3'd5, 0, 16'h0000, 0, 16'd3);
    add(1, 16'h2004, 0, 0,  1, 5'd1, 3'd0, 3'd0, 3'd0, 0, 16'h0000, 1, 16'd3);
    add(0, 16'h0000, 1, 0,  1, 5'd1, 3'd0, 3'd0, 3'd0, 0, 16'h0000, 0, 16'd3);
    add(0, 16'h0000, 1, 0,  1, 5'd4, 3'd0, 3'd0, 3'd1, 0, 16'h0000, 1, 16'd3);
    add(0, 16'h0000, 1, 0,  0, 5'd0, 3'd0, 3'd0, 3'd0, 0, 16'h0000, 1, 16'd3);
    // flush drops a held opcode; word during flush not taken
    add(1, 16'h0A21, 1, 0,  0, 5'd0, 3'd0, 3'd0, 3'd0, 0, 16'h0000, 1, 16'd3);
    add(1, 16'h00FF, 1, 1,  0, 5'd0, 3'd0, 3'd0, 3'd0, 0, 16'h0000, 0, 16'd3);
    add(1, 16'h1234, 1, 0,  0, 5'd0, 3'd0, 3'd0, 3'd0, 0, 16'h0000, 1, 16'd3);
    add(0, 16'h0000, 1, 0,  1, 5'd2, 3'd2, 3'd1, 3'd5, 0, 16'h0000, 1, 16'd3);
    add(0, 16'h0000, 1, 0,  0, 5'd0, 3'd0, 3'd0, 3'd0, 0, 16'h0000, 1, 16'd3);
    // flush empties a non-empty FIFO
    add(1, 16'h1234, 0, 0,  0, 5'd0, 3'd0, 3'd0, 3'd0, 0, 16'h0000, 1, 16'd3);
    add(0, 16'h0000, 0, 1,  1, 5'd2, 3'd2, 3'd1, 3'd5, 0, 16'h0000, 0, 16'd3);
    add(0, 16'h0000, 0, 0,  0, 5'd0, 3'd0, 3'd0, 3'd0, 0, 16'h0000, 1, 16'd3);

    #12;
    chk("reset out_valid", -1, {15'h0, out_valid}, 16'h0);
    chk("reset in_ready",  -1, {15'h0, in_ready},  16'h1);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      t = vecs[i];
      in_valid = t.v; in_instr = t.w; out_ready = t.rdy; flush = t.fl;
      #1;
      chk_all(i, t);
    end

    // Asynchronous reset mid-instruction with two entries queued
    @(negedge clk);
    in_valid = 1'b1; in_instr = 16'h1234; out_ready = 1'b0; flush = 1'b0;
    @(negedge clk);
    in_instr = 16'h0800;
    @(negedge clk);
    #1;
    chk("pre-reset in_ready", 100, {15'h0, in_ready}, 16'h0);
    chk("pre-reset out_valid", 100, {15'h0, out_valid}, 16'h1);
    in_valid = 1'b0;
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    chk("async out_valid",  101, {15'h0, out_valid},  16'h0);
    chk("async in_ready",   101, {15'h0, in_ready},   16'h1);
    chk("async out_opcode", 101, {11'h0, out_opcode}, 16'h0);
    chk("async nop_count",  101, nop_count,           16'h0);
    @(negedge clk);
    reset = 1'b0;
    in_valid = 1'b1; in_instr = 16'h1234; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    chk("post out_valid",   102, {15'h0, out_valid},   16'h1);
    chk("post out_opcode",  102, {11'h0, out_opcode},  16'h2);
    chk("post out_rsrc2",   102, {13'h0, out_rsrc2},   16'h5);
    chk("post out_has_imm", 102, {15'h0, out_has_imm}, 16'h0);
    chk("post out_imm",     102, out_imm,              16'h0);

    // Reset while in S_IMM: next opcode must not be paired with a stale hold
    @(negedge clk);
    in_valid = 1'b1; in_instr = 16'h0A21;
    @(negedge clk);
    in_valid = 1'b0;
    #3;
    reset = 1'b1;
    #2;
    reset = 1'b0;
    @(negedge clk);
    in_valid = 1'b1; in_instr = 16'h1234;
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    chk("s_imm reset out_valid",  103, {15'h0, out_valid},   16'h1);
    chk("s_imm reset out_opcode", 103, {11'h0, out_opcode},  16'h2);
    chk("s_imm reset has_imm",    103, {15'h0, out_has_imm}, 16'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
